// File: rtl/avalon_ram_responder.sv
// Avalon-MM word RAM slave with wait states, byte-lane write merge and reset-vector window.
// Optional macro AVALON_RAM_RANDOM_WAIT_EN adds an LFSR-driven jitter of 0..3 extra wait cycles.
module avalon_ram_responder #(
   parameter int unsigned MEM_WORDS     = 1024,
   parameter int unsigned WAIT_CYCLES   = 1,
   parameter logic [31:0] RESET_BASE    = 32'hBFC00000,
   parameter int unsigned ROM_WORD_BASE = 512
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic        waitrequest,
   output logic [31:0] readdata,
   output logic        err,
   output logic [1:0]  dbg_state_o
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_e;

   state_e      state_q;
   logic [4:0]  cnt_q;
   logic [31:0] readdata_q;
   logic        err_q;
   logic [31:0] mem_q [MEM_WORDS];

   logic        req;
   logic [31:0] rel;
   logic [31:0] idx;
   logic [AW-1:0] widx;
   logic        bad;
   logic [31:0] mem_rd;
   logic [4:0]  cnt_d;

   assign req = read | write;

   // Requests in the reset-vector window land in the instruction region of the same array.
   always_comb begin
      rel = address - RESET_BASE;
      if (address >= RESET_BASE) begin
         idx = (rel >> 2) + 32'(ROM_WORD_BASE);
      end else begin
         idx = address >> 2;
      end
      bad = (address[1:0] != 2'b00) || (idx >= 32'(MEM_WORDS)) || (read && write);
   end

   assign widx   = idx[AW-1:0];
   assign mem_rd = mem_q[widx];

`ifdef AVALON_RAM_RANDOM_WAIT_EN
   logic [7:0] lfsr_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_q <= 8'hA5;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   assign cnt_d = 5'(WAIT_CYCLES) + {3'b000, lfsr_q[1:0]};
`else
   assign cnt_d = 5'(WAIT_CYCLES);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 5'd0;
         readdata_q <= 32'h0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  cnt_q <= cnt_d;
                  if (cnt_d == 5'd0) begin
                     state_q <= ACK;
                     if (bad) begin
                        readdata_q <= 32'h0;
                        err_q      <= 1'b1;
                     end else if (read) begin
                        readdata_q <= mem_rd;
                     end
                  end else begin
                     state_q <= BUSY;
                  end
               end
            end
            BUSY: begin
               // A master that withdraws its request abandons the access without side effects.
               if (!req) begin
                  state_q <= IDLE;
               end else if (cnt_q == 5'd1) begin
                  state_q <= ACK;
                  if (bad) begin
                     readdata_q <= 32'h0;
                     err_q      <= 1'b1;
                  end else if (read) begin
                     readdata_q <= mem_rd;
                  end
               end else begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            ACK: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Storage has no reset; the write commits on the edge leaving ACK.
   always_ff @(posedge clk) begin
      if (state_q == ACK && write && !bad) begin
         for (int i = 0; i < 4; i++) begin
            if (byteenable[i]) begin
               mem_q[widx][8*i +: 8] <= writedata[8*i +: 8];
            end
         end
      end
   end

   assign waitrequest = req && (state_q != ACK);
   assign readdata    = readdata_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/avalon_ram_responder.md
Name: avalon_ram_responder

Overview:
- Avalon-MM memory slave that answers the bus master in mips_cpu_bus.
- Word-addressed 32-bit data path with byteenable write merging, and a parameterised number of wait states.
- Maps the MIPS reset-vector window at 0xBFC00000 onto an instruction region inside the same RAM.
- Used as the synthesisable memory model in CPU benches, replacing the combinational RAM array.

Parameters:
- MEM_WORDS, 1024: words of storage; word index range 0..MEM_WORDS-1.
- WAIT_CYCLES, 1: extra waitrequest-high cycles per access (0..15).
- RESET_BASE, 32'hBFC00000: byte address of the start of the reset-vector window.
- ROM_WORD_BASE, 512: word index that RESET_BASE maps to.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- address  input  32  byte address from master.
- read  input  1  read request.
- write  input  1  write request.
- writedata  input  32  write data.
- byteenable  input  4  lane enables; lane i = bits [8i+7:8i].
- waitrequest  output  1  stall; the transfer completes in a cycle where read|write=1 and waitrequest=0.
- readdata  output  32  read data, valid in the completing cycle.
- err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, cnt=0, readdata=0, err=0.
  - waitrequest follows its comb rule (reads 0 with no request).
  - A pending write is discarded. Memory contents are not cleared.
- waitrequest = (read|write) && state!=ACK. Combinational from state and request.
- Address map:
  - If address>=RESET_BASE: idx = ((address-RESET_BASE)>>2) + ROM_WORD_BASE.
  - Otherwise: idx = address>>2.
  - Arithmetic is 32-bit unsigned.
- An access is bad if any of the following holds: address[1:0]!=0, idx>=MEM_WORDS, or read&&write.
- FSM IDLE -> BUSY -> ACK:
  - IDLE: if read|write, load cnt=WAIT_CYCLES. If WAIT_CYCLES==0, go directly to ACK (same edge performs the read latch, see below). Otherwise go to BUSY.
  - BUSY: if read|write drops, abort to IDLE; no memory effect and err is unchanged. Else if cnt==1, go to ACK. Else cnt-=1.
  - On the edge entering ACK: for a good read, readdata <= mem[idx]. For a bad access, readdata <= 0 and err <= 1.
  - ACK: waitrequest=0. On the leaving edge, for a good write, mem[idx] lane i <= writedata lane i for every byteenable[i]=1; other lanes are held. Bad writes change nothing. Next state is IDLE.
- readdata holds its last value outside ACK.
- Lane/byte order: lane i corresponds to byte address idx*4+i.
- Latency: every access occupies WAIT_CYCLES+2 cycles from request assertion to the cycle after completion. Back-to-back requests return through IDLE; there is no pipelining.
- byteenable=0000 on a write completes normally and modifies nothing.
- byteenable is ignored on reads; the full word is returned.
- address/writedata/byteenable changing while waitrequest=1 is a master protocol violation. Values sampled on the latch edge (read) and the ACK edge (write) are the ones used.
- A bad access still completes (waitrequest drops in ACK) so the master never hangs.

Optional Feature:
- Macro: AVALON_RAM_RANDOM_WAIT_EN.
- With the macro defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and advances every clk.
  - The IDLE load becomes cnt = WAIT_CYCLES + lfsr[1:0].
  - A total of 0 behaves as the WAIT_CYCLES==0 path.
- Without the macro: no LFSR is present and the wait count is fixed at WAIT_CYCLES.

Test Plan:
- Reset then idle, WAIT_CYCLES=1: readdata=0, err=0, waitrequest=0 while read=write=0.
- Preload mem[25]=32'hAABBCCDD, read address 100: waitrequest high for 2 cycles, low for 1 cycle with readdata=32'hAABBCCDD.
- Write 32'h11223344 to address 200 with be=0101 over an old word 32'hFFFFFFFF, then read address 200 -> 32'hFF22FF44.
- Read address 32'hBFC00004 with mem[513]=32'h8C010064 -> readdata=32'h8C010064.
- Read address 32'h00000102 -> completes with readdata=0 and err=1; later good accesses still work and err stays 1.
- Write to address 300 dropped mid-BUSY (WAIT_CYCLES=3) -> FSM returns to IDLE and mem[75] is unchanged. Separately, assert reset low during ACK of a write -> write discarded and all outputs at reset values.
